// File: rtl/hz_pkg.sv
// rtl/hz_pkg.sv - shared codes, types and helpers for the hazard controller
package hz_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    ALU  = 2'b01,
    DM   = 2'b10,
    PC8  = 2'b11
  } src_t;

  localparam logic [2:0] F_RF   = 3'b000;
  localparam logic [2:0] F_DMW  = 3'b001;
  localparam logic [2:0] F_AOW  = 3'b010;
  localparam logic [2:0] F_PC8W = 3'b011;
  localparam logic [2:0] F_PC8M = 3'b100;
  localparam logic [2:0] F_AOM  = 3'b101;

  typedef struct packed {
    logic [4:0] a3;
    src_t       src;
    logic [1:0] tnew;
  } stage_t;

  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // $0 is hard-wired, so it can never be a true producer/consumer pair
  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] a3);
    return (r != 5'd0) && (r == a3);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// rtl/hazard_ctrl_fwd_sel.sv - forwarding mux select for one consumed register
module fwd_sel
  import hz_pkg::*;
(
  input  logic [4:0] reg_i,
  input  logic [4:0] a3_m_i,
  input  src_t       src_m_i,
  input  logic [4:0] a3_w_i,
  input  src_t       src_w_i,
  output logic [2:0] sel_o
);

  // A load still in M has no data yet, so it falls through to the W check
  always_comb begin
    sel_o = F_RF;
    if (reg_match(reg_i, a3_m_i) && src_m_i == ALU) begin
      sel_o = F_AOM;
    end else if (reg_match(reg_i, a3_m_i) && src_m_i == PC8) begin
      sel_o = F_PC8M;
    end else if (reg_match(reg_i, a3_w_i)) begin
      case (src_w_i)
        DM:      sel_o = F_DMW;
        ALU:     sel_o = F_AOW;
        PC8:     sel_o = F_PC8W;
        default: sel_o = F_RF;
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall and forwarding control with E/M/W shadow pipeline
module hazard_ctrl
  import hz_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [1:0] tuse_rs,
  input  logic [1:0] tuse_rt,
  input  logic [4:0] a3_d,
  input  logic [1:0] tnew_d,
  input  logic [1:0] src_d,
  output logic       stall,
  output logic [2:0] f_rsd,
  output logic [2:0] f_rtd,
  output logic [2:0] f_rse,
  output logic [2:0] f_rte,
  output logic       f_rtm
);

  stage_t     e_q, e_d, m_q, m_d;
  logic [4:0] a3_w_q, a3_w_d;
  src_t       src_w_q, src_w_d;
  logic [4:0] rs_e_q, rs_e_d, rt_e_q, rt_e_d, rt_m_q, rt_m_d;
  logic       stall_rs, stall_rt;

  // An E-stage producer can never feed a D-stage consumer, hence the tuse==0 term
  always_comb begin
    stall_rs = (reg_match(rs_d, e_q.a3) && (e_q.tnew > tuse_rs || tuse_rs == 2'd0))
            || (reg_match(rs_d, m_q.a3) && (m_q.tnew > tuse_rs));
    stall_rt = (reg_match(rt_d, e_q.a3) && (e_q.tnew > tuse_rt || tuse_rt == 2'd0))
            || (reg_match(rt_d, m_q.a3) && (m_q.tnew > tuse_rt));
    stall    = stall_rs | stall_rt;
  end

  always_comb begin
    e_d    = stage_t'('0);
    rs_e_d = 5'd0;
    rt_e_d = 5'd0;
    if (!stall) begin
      e_d.a3   = a3_d;
      e_d.src  = src_t'(src_d);
      e_d.tnew = tnew_d;
      rs_e_d   = rs_d;
      rt_e_d   = rt_d;
    end
    m_d.a3   = e_q.a3;
    m_d.src  = e_q.src;
    m_d.tnew = dec_sat(e_q.tnew);
    a3_w_d   = m_q.a3;
    src_w_d  = m_q.src;
    rt_m_d   = rt_e_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q     <= stage_t'('0);
      m_q     <= stage_t'('0);
      a3_w_q  <= 5'd0;
      src_w_q <= NONE;
      rs_e_q  <= 5'd0;
      rt_e_q  <= 5'd0;
      rt_m_q  <= 5'd0;
    end else begin
      e_q     <= e_d;
      m_q     <= m_d;
      a3_w_q  <= a3_w_d;
      src_w_q <= src_w_d;
      rs_e_q  <= rs_e_d;
      rt_e_q  <= rt_e_d;
      rt_m_q  <= rt_m_d;
    end
  end

  fwd_sel u_fwd_rsd (.reg_i(rs_d),   .a3_m_i(m_q.a3), .src_m_i(m_q.src),
                     .a3_w_i(a3_w_q), .src_w_i(src_w_q), .sel_o(f_rsd));
  fwd_sel u_fwd_rtd (.reg_i(rt_d),   .a3_m_i(m_q.a3), .src_m_i(m_q.src),
                     .a3_w_i(a3_w_q), .src_w_i(src_w_q), .sel_o(f_rtd));
  fwd_sel u_fwd_rse (.reg_i(rs_e_q), .a3_m_i(m_q.a3), .src_m_i(m_q.src),
                     .a3_w_i(a3_w_q), .src_w_i(src_w_q), .sel_o(f_rse));
  fwd_sel u_fwd_rte (.reg_i(rt_e_q), .a3_m_i(m_q.a3), .src_m_i(m_q.src),
                     .a3_w_i(a3_w_q), .src_w_i(src_w_q), .sel_o(f_rte));

  assign f_rtm = reg_match(rt_m_q, a3_w_q);

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, a3_d;
  logic [1:0] tuse_rs, tuse_rt, tnew_d, src_d;
  logic       stall, f_rtm;
  logic [2:0] f_rsd, f_rtd, f_rse, f_rte;
  logic [13:0] obs;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d), .tuse_rs(tuse_rs),
    .tuse_rt(tuse_rt), .a3_d(a3_d), .tnew_d(tnew_d), .src_d(src_d),
    .stall(stall), .f_rsd(f_rsd), .f_rtd(f_rtd), .f_rse(f_rse),
    .f_rte(f_rte), .f_rtm(f_rtm)
  );

  // {stall, f_rsd, f_rtd, f_rse, f_rte, f_rtm}
  assign obs = {stall, f_rsd, f_rtd, f_rse, f_rte, f_rtm};

  task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] ur,
                     input logic [1:0] ut, input logic [4:0] a3, input logic [1:0] tn,
                     input logic [1:0] src);
    rs_d = rs; rt_d = rt; tuse_rs = ur; tuse_rt = ut; a3_d = a3; tnew_d = tn; src_d = src;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    drv(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 2'b00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nop();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== 14'b0_000_000_000_000_0) begin
      errors++; $display("FAIL reset_state got=%b exp=%b", obs, 14'b0);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drv(5'd29, 5'd0, 2'd1, 2'd3, 5'd1, 2'd2, 2'b10);   // lw $1
    tick();
    drv(5'd1, 5'd3, 2'd1, 2'd1, 5'd2, 2'd1, 2'b01);    // add $2,$1,$3
    checks++;
    if (obs !== 14'b1_000_000_000_000_0) begin
      errors++; $display("FAIL lw_add_stall got=%b exp=%b", obs, 14'b1_000_000_000_000_0);
    end
    tick();
    checks++;
    if (obs !== 14'b0_000_000_000_000_0) begin
      errors++; $display("FAIL lw_add_bubble got=%b exp=%b", obs, 14'b0);
    end
    tick();
    nop();
    checks++;
    if (obs !== 14'b0_000_000_001_000_0) begin
      errors++; $display("FAIL lw_add_frse got=%b exp=%b", obs, 14'b0_000_000_001_000_0);
    end
  endtask

  task automatic test_alu_branch();
    do_reset();
    drv(5'd2, 5'd3, 2'd1, 2'd1, 5'd1, 2'd1, 2'b01);    // add $1
    tick();
    drv(5'd1, 5'd4, 2'd0, 2'd0, 5'd0, 2'd0, 2'b00);    // beq $1,$4
    checks++;
    if (obs !== 14'b1_000_000_000_000_0) begin
      errors++; $display("FAIL add_beq_stall got=%b exp=%b", obs, 14'b1_000_000_000_000_0);
    end
    tick();
    checks++;
    if (obs !== 14'b0_101_000_000_000_0) begin
      errors++; $display("FAIL add_beq_aom got=%b exp=%b", obs, 14'b0_101_000_000_000_0);
    end
    tick();
    checks++;
    if (obs !== 14'b0_010_000_010_000_0) begin
      errors++; $display("FAIL add_beq_aow got=%b exp=%b", obs, 14'b0_010_000_010_000_0);
    end
  endtask

  task automatic test_jal_jr();
    do_reset();
    drv(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 2'b11);   // jal
    tick();
    drv(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 2'b00);   // jr $31
    checks++;
    if (obs !== 14'b1_000_000_000_000_0) begin
      errors++; $display("FAIL jal_jr_stall got=%b exp=%b", obs, 14'b1_000_000_000_000_0);
    end
    tick();
    checks++;
    if (obs !== 14'b0_100_000_000_000_0) begin
      errors++; $display("FAIL jal_jr_pc8m got=%b exp=%b", obs, 14'b0_100_000_000_000_0);
    end
  endtask

  task automatic test_load_store();
    do_reset();
    drv(5'd29, 5'd0, 2'd1, 2'd3, 5'd5, 2'd2, 2'b10);   // lw $5
    tick();
    drv(5'd6, 5'd5, 2'd1, 2'd2, 5'd0, 2'd0, 2'b00);    // sw $5,0($6)
    checks++;
    if (obs !== 14'b0_000_000_000_000_0) begin
      errors++; $display("FAIL lw_sw_nostall got=%b exp=%b", obs, 14'b0);
    end
    tick();
    nop();
    checks++;
    if (obs !== 14'b0_000_000_000_000_0) begin
      errors++; $display("FAIL lw_sw_in_e got=%b exp=%b", obs, 14'b0);
    end
    tick();
    checks++;
    if (obs !== 14'b0_000_000_000_000_1) begin
      errors++; $display("FAIL lw_sw_frtm got=%b exp=%b", obs, 14'b0_000_000_000_000_1);
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    drv(5'd2, 5'd3, 2'd1, 2'd1, 5'd0, 2'd1, 2'b01);    // add $0
    tick();
    drv(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 2'b00);    // beq $0,$0
    checks++;
    if (obs !== 14'b0_000_000_000_000_0) begin
      errors++; $display("FAIL zero_e got=%b exp=%b", obs, 14'b0);
    end
    tick();
    checks++;
    if (obs !== 14'b0_000_000_000_000_0) begin
      errors++; $display("FAIL zero_m got=%b exp=%b", obs, 14'b0);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drv(5'd29, 5'd0, 2'd1, 2'd3, 5'd1, 2'd2, 2'b10);   // lw $1
    tick();
    drv(5'd1, 5'd4, 2'd0, 2'd0, 5'd0, 2'd0, 2'b00);    // beq $1,$4
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL mid_stall_pre got=%b exp=1", stall);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (obs !== 14'b0_000_000_000_000_0) begin
      errors++; $display("FAIL mid_stall_reset got=%b exp=%b", obs, 14'b0);
    end
    tick();
    drv(5'd29, 5'd0, 2'd1, 2'd3, 5'd1, 2'd2, 2'b10);   // lw $1
    tick();
    drv(5'd1, 5'd4, 2'd0, 2'd0, 5'd0, 2'd0, 2'b00);    // beq $1,$4
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL lw_beq_stall1 got=%b exp=1", stall);
    end
    tick();
    checks++;
    if (obs !== 14'b1_000_000_000_000_0) begin
      errors++; $display("FAIL lw_beq_stall2 got=%b exp=%b", obs, 14'b1_000_000_000_000_0);
    end
    tick();
    checks++;
    if (obs !== 14'b0_001_000_000_000_0) begin
      errors++; $display("FAIL lw_beq_dmw got=%b exp=%b", obs, 14'b0_001_000_000_000_0);
    end
  endtask

  task automatic test_m_w_priority();
    do_reset();
    drv(5'd2, 5'd3, 2'd1, 2'd1, 5'd1, 2'd1, 2'b01);    // add $1 (older)
    tick();
    drv(5'd2, 5'd3, 2'd1, 2'd1, 5'd1, 2'd1, 2'b01);    // add $1 (younger)
    tick();
    nop();
    tick();
    drv(5'd1, 5'd1, 2'd1, 2'd1, 5'd7, 2'd1, 2'b01);    // add $7,$1,$1
    checks++;
    if (obs !== 14'b0_101_101_000_000_0) begin
      errors++; $display("FAIL mw_prio_d got=%b exp=%b", obs, 14'b0_101_101_000_000_0);
    end
    tick();
    nop();
    checks++;
    if (obs !== 14'b0_000_000_010_010_0) begin
      errors++; $display("FAIL mw_prio_e got=%b exp=%b", obs, 14'b0_000_000_010_010_0);
    end
  endtask

  initial begin
    reset = 1'b1;
    rs_d = '0; rt_d = '0; a3_d = '0; tuse_rs = '0; tuse_rt = '0; tnew_d = '0; src_d = '0;
    test_reset();
    test_load_use();
    test_alu_branch();
    test_jal_jr();
    test_load_store();
    test_zero_reg();
    test_reset_mid_stall();
    test_m_w_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Stall-and-forward controller for the five-stage MIPS pipeline. It keeps its own shadow pipeline of destination register, result source and remaining latency (Tnew) for the E, M and W stages. Each cycle it decides whether the instruction in D must stall. It also produces the select codes for the D-, E- and M-stage forwarding multiplexers (FRSD, FRTD, FRSE, FRTE, FRTM). It sits beside the datapath and is fed by the D-stage decoder.

## Interface
Parameters:
- none; all widths and codes are fixed by the package.

Ports:
- `clk`  in  1  pipeline clock
- `reset`  in  1  synchronous, active-high; clears all shadow state
- `rs_d`  in  5  rs field of the instruction in D
- `rt_d`  in  5  rt field of the instruction in D
- `tuse_rs`  in  2  cycles until rs is consumed (0 = used in D, 1 = used in E, 2 = used in M)
- `tuse_rt`  in  2  same for rt
- `a3_d`  in  5  destination register of the D instruction; 0 means no write
- `tnew_d`  in  2  cycles until the result exists, counted from entry into E (PC8 = 0, ALU = 1, load = 2)
- `src_d`  in  2  result source: 00 none, 01 ALU, 10 DM, 11 PC8
- `stall`  out  1  freezes PC and F/D; D/E loads a bubble
- `f_rsd`, `f_rtd`  out  3  D-stage select codes
- `f_rse`, `f_rte`  out  3  E-stage select codes
- `f_rtm`  out  1  M-stage store-data select

Select codes:
- 000 register file / pipe register
- 001 DMout (W)
- 010 AOW
- 011 PC8W
- 100 PC8M
- 101 AOM
- 110 reserved; never driven

## Operation
Shadow registers:
- Per stage X ∈ {E, M, W}: `a3_X`, `src_X`, `tnew_X`.
- Also `rs_e`, `rt_e`, `rt_m`.

Advance on each rising `clk`:
- E loads the D fields. If `stall` is high, E instead loads a bubble: every field zero.
- M loads from E, with `tnew` decremented and saturating at 0.
- W loads from M the same way.
- `rt_m` loads from `rt_e`.

Match rule:
- A register `r` matches stage X when `r != 0` and `r == a3_X`.
- Register 0 never matches and is never forwarded.

Stall (combinational, per operand `r` with its `tuse`):
- E match and `tnew_E > tuse` → stall.
- E match and `tuse == 0` → stall. No E-stage source exists for D consumers.
- M match and `tnew_M > tuse` → stall.
- `stall = stall_rs | stall_rt`.

D-stage selects, applied to rs and rt; the youngest matching stage wins:
- M match with `src_M` ALU → 101; with PC8 → 100.
- Otherwise W match with DM → 001; ALU → 010; PC8 → 011.
- Otherwise 000.

E-stage selects use `rs_e`/`rt_e` with the same M-then-W priority and the same codes.

`f_rtm`:
- 1 when `rt_m` matches W, so M4 carries the W write-back data.
- Otherwise 0.

Outputs are valid even when `stall` is high. The datapath ignores the D-stage selects during a stall.

## Timing
- Reset value: all shadow registers 0, therefore `stall = 0` and every select = 000 / 0.
- Latency: all outputs are combinational from the current shadow state and the D inputs, with zero cycles of delay. State updates on the next edge.
- A load followed by a dependent ALU op (`tuse = 1`) stalls exactly 1 cycle.
- A load followed by a branch (`tuse = 0`) stalls 2 cycles.
- Reset asserted mid-stall: the next cycle shows `stall = 0` and all selects 000. Any pending bubble is discarded.
- Simultaneous matches in M and W: M wins. The same register in both D operands gets identical codes on both.

## Structure
- Package `hz_pkg`:
  - `src_t` enum: NONE, ALU, DM, PC8.
  - Select localparams: `F_RF`, `F_DMW`, `F_AOW`, `F_PC8W`, `F_PC8M`, `F_AOM`.
- One sub-module, `fwd_sel`: combinational; inputs are a register number plus the M and W shadow fields; output is the 3-bit code. It is instantiated four times (rsd, rtd, rse, rte).
- The stall logic and shadow registers live in the top level.

## Test plan
- `lw $1` then `add $2,$1,$3` → stall 1 for 1 cycle, E bubble, then `f_rse = 001`.
- `add $1` then `beq $1,$4` → stall 1 for 1 cycle, then `f_rsd = 101`. Next cycle, if the beq is still in D, `f_rsd = 010`.
- `jal` (a3 = 31, PC8) then `jr $31` → stall 1 cycle, then `f_rsd = 100`.
- `lw $5` then `sw $5,0($6)` → no stall; when the sw is in M, `f_rtm = 1`.
- `add $0,...` then a consumer of `$0` → no stall, all selects 000.
- Reset asserted during the `lw`/`beq` stall → next cycle stall 0 and all selects 000; a fresh sequence then behaves as above.
